remap_ctrl: RTL and testbench
=============================

Name: remap_ctrl

Overview:
- Control and coordinate-generation stage of the remap core.
- Walks the destination frame in raster order and consumes one map entry per destination pixel. Each map entry is a signed fixed-point source (x, y).
- Emits one fetch request per pixel to the downstream bilinear fetch/interpolate stage: integer source address, fractional weights, out-of-bounds flag, and frame/line markers.
- Sequencing is driven by a start/abort/done command interface from the register block.

Parameters:
- DATA_WIDTH, 16: width of each signed map coordinate (map_x, map_y).
- FRAC_BITS, 4: fractional bits in each map coordinate; 1 <= FRAC_BITS < DATA_WIDTH.
- DIM_WIDTH, 12: width of frame dimension config and pixel counters (max 4095x4095).
- CNT_WIDTH, 24: width of the saturating out-of-bounds counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame start pulse; honoured only in IDLE.
- abort  in  1  single-cycle abort pulse; honoured in any state.
- cfg_width  in  DIM_WIDTH  destination frame width in pixels; latched on start.
- cfg_height  in  DIM_WIDTH  destination frame height in lines; latched on start.
- map_valid  in  1  map stream beat valid.
- map_ready  out  1  map stream beat accepted.
- map_x  in  DATA_WIDTH  signed source x, FRAC_BITS fractional.
- map_y  in  DATA_WIDTH  signed source y, FRAC_BITS fractional.
- req_valid  out  1  request valid.
- req_ready  in  1  downstream accepts request.
- req_x  out  DATA_WIDTH-FRAC_BITS  integer source x, unsigned after OOB clamp.
- req_y  out  DATA_WIDTH-FRAC_BITS  integer source y, unsigned after OOB clamp.
- req_fx  out  FRAC_BITS  x weight.
- req_fy  out  FRAC_BITS  y weight.
- req_oob  out  1  source neighbourhood lies outside the frame; downstream outputs black.
- req_sof  out  1  first pixel of frame.
- req_eol  out  1  last pixel of line.
- req_eof  out  1  last pixel of frame.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- oob_cnt  out  CNT_WIDTH  saturating OOB count for the current frame; cleared on start.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters, latched config and output register cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN: start with nonzero cfg_width and cfg_height. Latch config, clear col/row/oob_cnt.
  - IDLE -> DONE: start with either dimension zero. No beats are emitted.
  - RUN -> DRAIN: the map beat for (width-1, height-1) is accepted.
  - DRAIN -> DONE: the output register is empty, or empties this cycle through a req handshake.
  - DONE -> IDLE: unconditionally after one cycle. done=1 only in DONE.
- map_ready = (state==RUN) && (!req_valid || req_ready). This gives one request per cycle at full throughput.
- Latency: map beat accepted at cycle N -> req_valid=1 at N+1 with that beat's fields.
- req_* fields are held stable while req_valid && !req_ready.
- Coordinate arithmetic:
  - ix = map_x >>> FRAC_BITS (arithmetic shift).
  - fx = map_x[FRAC_BITS-1:0].
  - y is handled identically.
- OOB rule: ix<0 or ix>width-2 or iy<0 or iy>height-2. The comparison is signed with zero-extended config; width==1 always gives OOB.
- When OOB: req_x, req_y, req_fx and req_fy are forced to 0; req_oob=1; oob_cnt increments, saturating at all-ones.
- Markers:
  - sof at (col 0, row 0).
  - eol at col==width-1.
  - eof at col==width-1 and row==height-1.
- Counters advance only on map handshake. col wraps to 0 at width-1 and row then increments.
- start outside IDLE is ignored. cfg changes after start have no effect until the next start.
- abort: next cycle state=IDLE, req_valid=0, busy=0, no done pulse. oob_cnt holds its value. abort wins over a simultaneous start.
- Map beats arriving while map_ready=0 are not consumed. There is no internal map buffering beyond the output register.

Decomposition:
- Package remap_pkg holds:
  - typedef enum state_t {IDLE, RUN, DRAIN, DONE}.
  - Packed struct remap_req_t {x, y, fx, fy, oob, sof, eol, eof}, parametrised through package localparams matching the defaults.
  - Function split_coord(), which returns the integer/fraction split.
- One sub-module, remap_coord_calc: purely combinational shift, split, OOB check and clamp. It is instantiated twice, once for x and once for y.
- The FSM, counters and output register stay in remap_ctrl.

Test Plan:
- 4x2 frame, in-range map (x=0x0018, y=0x0008), req_ready=1 -> 8 requests on consecutive cycles; req_x=1, req_fx=8, req_y=0, req_fy=8; sof on beat 0; eol on beats 3 and 7; eof on beat 7; done pulse 2 cycles after last map handshake; oob_cnt=0.
- 4x2 frame, map_x=-16 on pixel 0, x=0x0030 (ix=3) on pixel 1 -> both req_oob=1 with zeroed fields; oob_cnt=2.
- Random req_ready at 50% and random map_valid -> no request lost or duplicated; fields stable during stall; exactly width*height requests; map_ready low whenever req_valid && !req_ready.
- start with cfg_width=0 -> no req_valid; done pulses the cycle after start; busy stays 0.
- abort mid-frame with req_valid=1 stalled -> next cycle req_valid=0, busy=0, no done. A following start on a 2x2 frame completes normally with sof asserted.
- Force oob_cnt near saturation (CNT_WIDTH=2, all pixels OOB, 3x3 frame) -> oob_cnt stops at 3.

Source files
------------

// File: rtl/remap_pkg.sv
// Shared types and helpers for the remap control stage: FSM states, the
// request word and the fixed-point integer/fraction split.
package remap_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_FRAC_BITS  = 4;
   localparam int unsigned DEF_INT_WIDTH  = DEF_DATA_WIDTH - DEF_FRAC_BITS;
   localparam int unsigned DEF_DIM_WIDTH  = 12;
   localparam int unsigned DEF_CNT_WIDTH  = 24;
   localparam int unsigned SPLIT_W        = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [DEF_INT_WIDTH-1:0] x;
      logic [DEF_INT_WIDTH-1:0] y;
      logic [DEF_FRAC_BITS-1:0] fx;
      logic [DEF_FRAC_BITS-1:0] fy;
      logic                     oob;
      logic                     sof;
      logic                     eol;
      logic                     eof;
   } remap_req_t;

   typedef struct packed {
      logic signed [SPLIT_W-1:0] ipart;
      logic        [SPLIT_W-1:0] fpart;
   } coord_split_t;

   // Callers sign-extend their coordinate to SPLIT_W so one helper serves any width.
   function automatic coord_split_t split_coord(input logic signed [SPLIT_W-1:0] c,
                                                input int unsigned            frac_bits);
      coord_split_t s;
      s.ipart = c >>> frac_bits;
      s.fpart = c & ((SPLIT_W'(1) << frac_bits) - SPLIT_W'(1));
      return s;
   endfunction

endpackage

// File: rtl/remap_if.sv
// Map-in / request-out stream bundle of the remap control stage.
interface remap_if
   import remap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS
);

   logic                                map_valid;
   logic                                map_ready;
   logic signed [DATA_WIDTH-1:0]        map_x;
   logic signed [DATA_WIDTH-1:0]        map_y;

   logic                                req_valid;
   logic                                req_ready;
   logic [DATA_WIDTH-FRAC_BITS-1:0]     req_x;
   logic [DATA_WIDTH-FRAC_BITS-1:0]     req_y;
   logic [FRAC_BITS-1:0]                req_fx;
   logic [FRAC_BITS-1:0]                req_fy;
   logic                                req_oob;
   logic                                req_sof;
   logic                                req_eol;
   logic                                req_eof;

   modport master (
      input  map_valid, map_x, map_y, req_ready,
      output map_ready, req_valid, req_x, req_y, req_fx, req_fy,
             req_oob, req_sof, req_eol, req_eof
   );

   modport slave (
      output map_valid, map_x, map_y, req_ready,
      input  map_ready, req_valid, req_x, req_y, req_fx, req_fy,
             req_oob, req_sof, req_eol, req_eof
   );

endinterface

// File: rtl/remap_coord_calc.sv
// Splits one signed fixed-point map coordinate into integer/fraction parts
// and flags it when its 2-pixel neighbourhood leaves [0, dim-1].
module remap_coord_calc
   import remap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
   parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH
) (
   input  logic signed [DATA_WIDTH-1:0]           coord,
   input  logic        [DIM_WIDTH-1:0]            dim,
   output logic        [DATA_WIDTH-FRAC_BITS-1:0] int_part,
   output logic        [FRAC_BITS-1:0]            frac_part,
   output logic                                   oob
);

   localparam int unsigned INT_W = DATA_WIDTH - FRAC_BITS;

   coord_split_t              split;
   logic signed [SPLIT_W-1:0] ipart;
   logic signed [SPLIT_W-1:0] limit;
   logic                      unused_frac;

   always_comb begin
      split = split_coord({{(SPLIT_W-DATA_WIDTH){coord[DATA_WIDTH-1]}}, coord}, FRAC_BITS);
      ipart = split.ipart;
      // dim-2 goes negative for dim==1, so such frames are always out of bounds
      limit = $signed({{(SPLIT_W-DIM_WIDTH){1'b0}}, dim}) - 2;
      oob   = (ipart < 0) || (ipart > limit);
      int_part  = oob ? '0 : split.ipart[INT_W-1:0];
      frac_part = oob ? '0 : split.fpart[FRAC_BITS-1:0];
   end

   assign unused_frac = ^split.fpart[SPLIT_W-1:FRAC_BITS];

endmodule

// File: rtl/remap_ctrl.sv
// Remap control: walks the destination frame in raster order, consumes one
// map entry per pixel and emits one registered fetch request per pixel.
module remap_ctrl
   import remap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned FRAC_BITS  = DEF_FRAC_BITS,
   parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DIM_WIDTH-1:0] cfg_width,
   input  logic [DIM_WIDTH-1:0] cfg_height,
   remap_if.master              bus,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] oob_cnt
);

   localparam int unsigned INT_W = DATA_WIDTH - FRAC_BITS;

   state_t               state, state_d;
   logic [DIM_WIDTH-1:0] width_q, height_q, col, row;
   remap_req_t           req_q, req_d;
   logic                 req_valid_q;
   logic                 map_ready, map_fire, req_fire;
   logic                 last_col, last_row, cfg_ok;
   logic [INT_W-1:0]     ix, iy;
   logic [FRAC_BITS-1:0] fx, fy;
   logic                 oob_x, oob_y, oob;

   remap_coord_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .DIM_WIDTH  (DIM_WIDTH)
   ) u_calc_x (
      .coord     (bus.map_x),
      .dim       (width_q),
      .int_part  (ix),
      .frac_part (fx),
      .oob       (oob_x)
   );

   remap_coord_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .DIM_WIDTH  (DIM_WIDTH)
   ) u_calc_y (
      .coord     (bus.map_y),
      .dim       (height_q),
      .int_part  (iy),
      .frac_part (fy),
      .oob       (oob_y)
   );

   assign cfg_ok    = (cfg_width != '0) && (cfg_height != '0);
   assign map_ready = (state == RUN) && (!req_valid_q || bus.req_ready);
   assign map_fire  = map_ready && bus.map_valid;
   assign req_fire  = req_valid_q && bus.req_ready;
   assign last_col  = (col == width_q - DIM_WIDTH'(1));
   assign last_row  = (row == height_q - DIM_WIDTH'(1));

   // Either axis out of range blanks the whole request, not just that axis.
   always_comb begin
      oob       = oob_x || oob_y;
      req_d     = '0;
      req_d.oob = oob;
      if (!oob) begin
         req_d.x  = ix;
         req_d.y  = iy;
         req_d.fx = fx;
         req_d.fy = fy;
      end
      req_d.sof = (col == '0) && (row == '0);
      req_d.eol = last_col;
      req_d.eof = last_col && last_row;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:  if (start) state_d = cfg_ok ? RUN : DONE;
         RUN:   if (map_fire && last_col && last_row) state_d = DRAIN;
         DRAIN: if (!req_valid_q || req_fire) state_d = DONE;
         DONE:  state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q     <= '0;
         height_q    <= '0;
         col         <= '0;
         row         <= '0;
         oob_cnt     <= '0;
         req_q       <= '0;
         req_valid_q <= 1'b0;
      end else if (abort) begin
         req_valid_q <= 1'b0;
      end else begin
         if ((state == IDLE) && start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            col      <= '0;
            row      <= '0;
            oob_cnt  <= '0;
         end
         if (map_fire) begin
            req_q       <= req_d;
            req_valid_q <= 1'b1;
            if (last_col) begin
               col <= '0;
               row <= row + DIM_WIDTH'(1);
            end else begin
               col <= col + DIM_WIDTH'(1);
            end
            if (req_d.oob && (oob_cnt != '1)) oob_cnt <= oob_cnt + CNT_WIDTH'(1);
         end else if (req_fire) begin
            req_valid_q <= 1'b0;
         end
      end
   end

   assign bus.map_ready = map_ready;
   assign bus.req_valid = req_valid_q;
   assign bus.req_x     = req_q.x;
   assign bus.req_y     = req_q.y;
   assign bus.req_fx    = req_q.fx;
   assign bus.req_fy    = req_q.fy;
   assign bus.req_oob   = req_q.oob;
   assign bus.req_sof   = req_q.sof;
   assign bus.req_eol   = req_q.eol;
   assign bus.req_eof   = req_q.eof;
   assign busy          = (state == RUN) || (state == DRAIN);
   assign done          = (state == DONE);

endmodule

// File: tb/tb_remap_ctrl.sv
// Directed bench for remap_ctrl; a second instance with a 2-bit OOB counter
// shares all stimulus to exercise counter saturation.
module tb_remap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, abort;
   logic [11:0] cfg_width, cfg_height;
   logic        busy, done, busy2, done2;
   logic [23:0] oob_cnt;
   logic [1:0]  oob_cnt2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [63:0] got_q[$];
   int          got_cyc[$];
   int          done_cnt = 0, done_stamp = 0, start_stamp = 0;
   int          busy_cnt = 0, rv_cnt = 0, last_map_stamp = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_word = '0;

   remap_if bus  ();
   remap_if bus2 ();

   assign bus2.map_valid = bus.map_valid;
   assign bus2.map_x     = bus.map_x;
   assign bus2.map_y     = bus.map_y;
   assign bus2.req_ready = bus.req_ready;

   remap_ctrl u_dut (
      .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
      .cfg_width (cfg_width), .cfg_height (cfg_height), .bus (bus),
      .busy (busy), .done (done), .oob_cnt (oob_cnt)
   );

   remap_ctrl #(.CNT_WIDTH (2)) u_dut2 (
      .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
      .cfg_width (cfg_width), .cfg_height (cfg_height), .bus (bus2),
      .busy (busy2), .done (done2), .oob_cnt (oob_cnt2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pk(input int x, input int y, input int fx, input int fy,
                                      input bit oob, input bit sof, input bit eol, input bit eof);
      return {28'd0, 12'(x), 12'(y), 4'(fx), 4'(fy), oob, sof, eol, eof};
   endfunction

   function automatic logic [31:0] map_for(input int pat, input int p);
      case (pat)
         0: return {16'h0018, 16'h0008};
         1: begin
            if (p == 0)      return {16'hFFF0, 16'h0008};
            else if (p == 1) return {16'h0030, 16'h0008};
            else             return {16'h0018, 16'h0008};
         end
         2: return {16'h0010 + 16'(p), 16'(p)};
         default: return {16'hFFF0, 16'h0000};
      endcase
   endfunction

   always @(negedge clk) begin
      logic [63:0] cur;
      cur = {28'd0, bus.req_x, bus.req_y, bus.req_fx, bus.req_fy,
             bus.req_oob, bus.req_sof, bus.req_eol, bus.req_eof};
      if (bus.req_valid && bus.req_ready) begin
         got_q.push_back(cur);
         got_cyc.push_back(cyc);
      end
      if (bus.req_valid) rv_cnt++;
      if (done) begin
         done_cnt++;
         done_stamp = cyc;
      end
      if (busy) busy_cnt++;
      if (start) start_stamp = cyc;
      if (prev_stall && bus.req_valid) chk("stall_hold", cur, prev_word);
      if (bus.req_valid && !bus.req_ready) chk("mr_stall", 64'(bus.map_ready), 64'd0);
      prev_stall = bus.req_valid && !bus.req_ready;
      prev_word  = cur;
   end

   // Called and returns at posedge+1.
   task automatic do_start(input int w, input int h);
      cfg_width  = 12'(w);
      cfg_height = 12'(h);
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_done(input int base, input int budget);
      int g = 0;
      while ((done_cnt == base) && (g < budget)) begin
         @(posedge clk); #1;
         g++;
      end
      chk("done_seen", 64'(done_cnt - base), 64'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int w, input int h, input int pat, input bit rnd);
      int          p = 0;
      int          guard = 0;
      int          dbase;
      bit          fire;
      logic [31:0] m;
      dbase = done_cnt;
      do_start(w, h);
      cfg_width  = 12'd7;
      cfg_height = 12'd7;
      while ((p < w * h) && (guard < 600)) begin
         m             = map_for(pat, p);
         bus.map_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.req_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.map_x     = m[31:16];
         bus.map_y     = m[15:0];
         @(negedge clk);
         fire = bus.map_valid && bus.map_ready;
         if (fire) last_map_stamp = cyc;
         @(posedge clk); #1;
         if (fire) p++;
         guard++;
      end
      bus.map_valid = 1'b0;
      bus.req_ready = 1'b1;
      chk("beats_in", 64'(p), 64'(w * h));
      wait_done(dbase, 50);
   endtask

   initial begin
      int b, db, bb, rb;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_width = '0; cfg_height = '0;
      bus.map_valid = 1'b0; bus.map_x = '0; bus.map_y = '0; bus.req_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_map_ready", 64'(bus.map_ready), 64'd0);
      chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
      chk("rst_busy",      64'(busy),          64'd0);
      chk("rst_done",      64'(done),          64'd0);
      chk("rst_oob_cnt",   64'(oob_cnt),       64'd0);
      chk("rst_req_word",  {28'd0, bus.req_x, bus.req_y, bus.req_fx, bus.req_fy,
                            bus.req_oob, bus.req_sof, bus.req_eol, bus.req_eof}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 4x2 in-range frame at full throughput
      b = got_q.size();
      run_frame(4, 2, 0, 1'b0);
      chk("t1_count", 64'(got_q.size() - b), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("t1_req%0d", i), got_q[b+i], pk(1, 0, 8, 8, 0, i == 0, (i == 3) || (i == 7), i == 7));
      chk("t1_back2back", 64'(got_cyc[b+7] - got_cyc[b]), 64'd7);
      chk("t1_done_lat",  64'(done_stamp - last_map_stamp), 64'd2);
      chk("t1_oob_cnt",   64'(oob_cnt), 64'd0);
      chk("t1_busy_idle", 64'(busy), 64'd0);

      // 4x2 frame, pixel 0 has ix=-1 and pixel 1 has ix=3=width-1
      b = got_q.size();
      run_frame(4, 2, 1, 1'b0);
      chk("t2_count", 64'(got_q.size() - b), 64'd8);
      chk("t2_req0",  got_q[b+0], pk(0, 0, 0, 0, 1, 1, 0, 0));
      chk("t2_req1",  got_q[b+1], pk(0, 0, 0, 0, 1, 0, 0, 0));
      chk("t2_req2",  got_q[b+2], pk(1, 0, 8, 8, 0, 0, 0, 0));
      chk("t2_req7",  got_q[b+7], pk(1, 0, 8, 8, 0, 0, 1, 1));
      chk("t2_oob_cnt",  64'(oob_cnt),  64'd2);
      chk("t2_oob_cnt2", 64'(oob_cnt2), 64'd2);

      // 4x3 frame with random valid/ready; fractions carry the pixel index
      b = got_q.size();
      run_frame(4, 3, 2, 1'b1);
      chk("t3_count", 64'(got_q.size() - b), 64'd12);
      for (int i = 0; i < 12; i++)
         chk($sformatf("t3_req%0d", i), got_q[b+i], pk(1, 0, i, i, 0, i == 0, (i % 4) == 3, i == 11));
      chk("t3_oob_cnt", 64'(oob_cnt), 64'd0);

      // zero width: straight to DONE
      b = got_q.size(); db = done_cnt; bb = busy_cnt; rb = rv_cnt;
      do_start(0, 2);
      repeat (4) @(posedge clk);
      #1;
      chk("t4_no_req",   64'(rv_cnt - rb),   64'd0);
      chk("t4_no_busy",  64'(busy_cnt - bb), 64'd0);
      chk("t4_one_done", 64'(done_cnt - db), 64'd1);
      chk("t4_done_lat", 64'(done_stamp - start_stamp), 64'd1);

      // abort with a stalled request in flight
      db = done_cnt;
      bus.req_ready = 1'b0;
      do_start(4, 2);
      bus.map_valid = 1'b1; bus.map_x = 16'hFFF0; bus.map_y = 16'h0008;
      @(negedge clk);
      chk("t5_map_ready", 64'(bus.map_ready), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_req_valid", 64'(bus.req_valid), 64'd1);
      chk("t5_req_word",  {28'd0, bus.req_x, bus.req_y, bus.req_fx, bus.req_fy,
                           bus.req_oob, bus.req_sof, bus.req_eol, bus.req_eof}, pk(0, 0, 0, 0, 1, 1, 0, 0));
      @(posedge clk); #1;
      cfg_width = 12'd2; cfg_height = 12'd2; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("t5_start_ignored_busy", 64'(busy), 64'd1);
      chk("t5_start_ignored_rv",   64'(bus.req_valid), 64'd1);
      @(posedge clk); #1;
      abort = 1'b1; bus.map_valid = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("t5_abort_rv",   64'(bus.req_valid), 64'd0);
      chk("t5_abort_busy", 64'(busy), 64'd0);
      chk("t5_abort_hold", 64'(oob_cnt), 64'd1);
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("t5_abort_wins_busy", 64'(busy), 64'd0);
      chk("t5_abort_wins_cnt",  64'(oob_cnt), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_no_done", 64'(done_cnt - db), 64'd0);

      // 2x2 after abort: ix=1 > width-2 so every pixel is OOB
      bus.req_ready = 1'b1;
      b = got_q.size();
      run_frame(2, 2, 0, 1'b0);
      chk("t5b_count", 64'(got_q.size() - b), 64'd4);
      chk("t5b_req0",  got_q[b+0], pk(0, 0, 0, 0, 1, 1, 0, 0));
      chk("t5b_req1",  got_q[b+1], pk(0, 0, 0, 0, 1, 0, 1, 0));
      chk("t5b_req2",  got_q[b+2], pk(0, 0, 0, 0, 1, 0, 0, 0));
      chk("t5b_req3",  got_q[b+3], pk(0, 0, 0, 0, 1, 0, 1, 1));
      chk("t5b_oob_cnt",  64'(oob_cnt),  64'd4);
      chk("t5b_oob_cnt2", 64'(oob_cnt2), 64'd3);

      // 3x3 all OOB: the 2-bit counter saturates at 3
      b = got_q.size();
      run_frame(3, 3, 3, 1'b0);
      chk("t6_count",    64'(got_q.size() - b), 64'd9);
      chk("t6_req8",     got_q[b+8], pk(0, 0, 0, 0, 1, 0, 1, 1));
      chk("t6_oob_cnt",  64'(oob_cnt),  64'd9);
      chk("t6_oob_cnt2", 64'(oob_cnt2), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
